// File: rtl/alu_writeback_if.sv
// Handshake and register-file bus between the ALU result mux and the write-back stage.
interface alu_writeback_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] reg_a;
  logic [WIDTH-1:0] reg_b;
  logic             flag_z;
  logic             flag_n;
  logic             done;
  logic [CNT_W-1:0] op_count;

  // Upstream side: issues operations and observes the registers.
  modport master (
    output op_valid, opcode, result, load_data,
    input  op_ready, reg_a, reg_b, flag_z, flag_n, done, op_count
  );

  // Write-back stage side.
  modport slave (
    input  op_valid, opcode, result, load_data,
    output op_ready, reg_a, reg_b, flag_z, flag_n, done, op_count
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU write-back stage: commits results to A, B or flags and sequences the two-cycle swap.
module alu_writeback #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  alu_writeback_if.slave bus
);

  typedef enum logic {StIdle, StSwap2} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_tmp;
  logic [WIDTH-1:0] w_a_nxt, w_b_nxt, w_tmp_nxt;
  logic             r_z, r_n, r_done;
  logic             w_z_nxt, w_n_nxt, w_done_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_accept;

  assign w_accept = bus.op_valid && (r_state == StIdle);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath update; registers hold unless an op is accepted or a swap completes.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_tmp_nxt   = r_tmp;
    w_z_nxt     = r_z;
    w_n_nxt     = r_n;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_done_nxt = 1'b1;
          case (bus.opcode)
            4'h4: begin
              w_z_nxt = (bus.result == '0);
              w_n_nxt = bus.result[WIDTH-1];
            end
            4'hD: begin
              w_b_nxt = r_a;
              w_z_nxt = (r_a == '0);
              w_n_nxt = r_a[WIDTH-1];
            end
            4'hE: begin
              // Retirement is deferred to the second swap cycle.
              w_tmp_nxt   = r_a;
              w_a_nxt     = r_b;
              w_done_nxt  = 1'b0;
              w_state_nxt = StSwap2;
            end
            4'hF: begin
              w_a_nxt = bus.load_data;
              w_z_nxt = (bus.load_data == '0);
              w_n_nxt = bus.load_data[WIDTH-1];
            end
            default: begin
              w_a_nxt = bus.result;
              w_z_nxt = (bus.result == '0);
              w_n_nxt = bus.result[WIDTH-1];
            end
          endcase
        end
      end
      StSwap2: begin
        w_b_nxt     = r_tmp;
        w_done_nxt  = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
    w_cnt_nxt = w_done_nxt ? r_cnt + CNT_W'(1) : r_cnt;
  end

  // Architectural registers, done pulse and retired-op counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_tmp  <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_a    <= w_a_nxt;
      r_b    <= w_b_nxt;
      r_tmp  <= w_tmp_nxt;
      r_z    <= w_z_nxt;
      r_n    <= w_n_nxt;
      r_done <= w_done_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign bus.op_ready = (r_state == StIdle);
  assign bus.reg_a    = r_a;
  assign bus.reg_b    = r_b;
  assign bus.flag_z   = r_z;
  assign bus.flag_n   = r_n;
  assign bus.done     = r_done;
  assign bus.op_count = r_cnt;

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: driver pushes model expectations, monitor checks on done.
module tb_alu_writeback;
  localparam int W = 8;
  localparam int C = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_writeback_if #(.WIDTH(W), .CNT_W(C)) bus ();
  alu_writeback #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int a;
    int b;
    bit z;
    bit n;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int last_waits = 0;

  // Reference state.
  int m_a, m_b, m_cnt;
  bit m_z, m_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void set_flags(input int v);
    m_z = (v == 0);
    m_n = (v >= (1 << (W - 1)));
  endfunction

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_cnt = 0; m_z = 0; m_n = 0;
    sb.delete();
  endfunction

  // Apply one accepted operation to the reference and queue the state expected at its done.
  function automatic void model_apply(input int op, input int res, input int ld);
    exp_t e;
    int t;
    if (op == 4) begin
      set_flags(res);
    end else if (op == 13) begin
      m_b = m_a;
      set_flags(m_a);
    end else if (op == 14) begin
      t = m_a; m_a = m_b; m_b = t;
    end else if (op == 15) begin
      m_a = ld;
      set_flags(ld);
    end else begin
      m_a = res;
      set_flags(res);
    end
    m_cnt = (m_cnt + 1) % (1 << C);
    e.a = m_a; e.b = m_b; e.z = m_z; e.n = m_n; e.cnt = m_cnt;
    sb.push_back(e);
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("mon_reg_a", 32'(bus.reg_a), e.a);
        check("mon_reg_b", 32'(bus.reg_b), e.b);
        check("mon_flag_z", 32'(bus.flag_z), 32'(e.z));
        check("mon_flag_n", 32'(bus.flag_n), 32'(e.n));
        check("mon_op_count", 32'(bus.op_count), e.cnt);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.op_valid  = 1'b0;
      bus.opcode    = 4'($urandom);
      bus.result    = W'($urandom);
      bus.load_data = W'($urandom);
    end
  endtask

  task automatic issue(input int op, input int res, input int ld);
    bit acc;
    int waits;
    int old_b;
    acc = 0;
    waits = 0;
    @(negedge clk);
    bus.op_valid  = 1'b1;
    bus.opcode    = 4'(op);
    bus.result    = W'(res);
    bus.load_data = W'(ld);
    while (1) begin
      acc = (bus.op_ready === 1'b1);
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 8) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept op 0x%0h", op);
        break;
      end
      @(negedge clk);
    end
    last_waits = waits;
    if (acc) begin
      old_b = m_b;
      model_apply(op, res & ((1 << W) - 1), ld & ((1 << W) - 1));
      #1;
      bus.op_valid = 1'b0;
      if (op == 14) begin
        check("swp_first_a", 32'(bus.reg_a), old_b);
        check("swp_ready_low", 32'(bus.op_ready), 0);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.op_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] s_a, s_b;
    logic [C-1:0] s_cnt;
    logic         s_z, s_n;
    int ds0;
    rst = 1'b1;
    bus.op_valid = 1'b0;
    bus.opcode = '0;
    bus.result = '0;
    bus.load_data = '0;
    do_reset();

    // Reset values.
    check("rst_reg_a", 32'(bus.reg_a), 0);
    check("rst_reg_b", 32'(bus.reg_b), 0);
    check("rst_flag_z", 32'(bus.flag_z), 0);
    check("rst_flag_n", 32'(bus.flag_n), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_op_count", 32'(bus.op_count), 0);
    check("rst_op_ready", 32'(bus.op_ready), 1);

    // LOAD 0x5A.
    issue(15, 32'h33, 32'h5A);
    idle(1);
    check("load_a", 32'(bus.reg_a), 32'h5A);
    check("load_cnt", 32'(bus.op_count), 1);

    // ADD 0x80 then SUB 0x00 back to back.
    issue(0, 32'h80, 32'h11);
    issue(1, 32'h00, 32'h22);
    idle(1);
    check("sub_a", 32'(bus.reg_a), 0);
    check("sub_z", 32'(bus.flag_z), 1);
    check("sub_n", 32'(bus.flag_n), 0);
    check("sub_cnt", 32'(bus.op_count), 3);

    // STO, LOAD, SWP with a CMP held behind it.
    issue(15, 32'h00, 32'h12);
    issue(13, 32'hFF, 32'hFF);
    issue(15, 32'h00, 32'h34);
    issue(14, 32'hAA, 32'hBB);
    issue(4, 32'h00, 32'hCC);
    check("cmp_wait_cycles", last_waits, 1);
    idle(1);
    check("swp_a", 32'(bus.reg_a), 32'h12);
    check("swp_b", 32'(bus.reg_b), 32'h34);
    check("cmp_z", 32'(bus.flag_z), 1);

    // Swap back to A=0x34, B=0x12, then reset in the middle of a swap.
    issue(14, 0, 0);
    idle(2);
    issue(14, 0, 0);
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_a", 32'(bus.reg_a), 0);
    check("abort_b", 32'(bus.reg_b), 0);
    check("abort_z", 32'(bus.flag_z), 0);
    check("abort_n", 32'(bus.flag_n), 0);
    check("abort_cnt", 32'(bus.op_count), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_ready", 32'(bus.op_ready), 1);
    do_reset();
    idle(2);

    // 256 LOADs from reset wrap the counter.
    do_reset();
    ds0 = done_seen;
    for (int i = 0; i < 256; i++) issue(15, int'($urandom), int'($urandom));
    idle(2);
    check("wrap_cnt", 32'(bus.op_count), 0);
    check("wrap_dones", done_seen - ds0, 256);

    // Idle inputs toggling: nothing changes.
    s_a = bus.reg_a; s_b = bus.reg_b; s_z = bus.flag_z; s_n = bus.flag_n; s_cnt = bus.op_count;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check("idle_a", 32'(bus.reg_a), 32'(s_a));
      check("idle_b", 32'(bus.reg_b), 32'(s_b));
      check("idle_flags", {30'b0, bus.flag_z, bus.flag_n}, {30'b0, s_z, s_n});
      check("idle_cnt", 32'(bus.op_count), 32'(s_cnt));
      check("idle_done", 32'(bus.done), 0);
    end

    // Randomized mix of all opcodes with gaps.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else issue(int'($urandom_range(0, 15)), int'($urandom), int'($urandom));
    end
    idle(3);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
